// File: rtl/xil_mem_dp_be.sv
// rtl/xil_mem_dp_be.sv - dual-port byte-enable RAM with clear engine and collision flag
module xil_mem_dp_be #(
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       ADDR_W     = 11,
  parameter int unsigned       OUT_REG    = 0,
  parameter int unsigned       WRITE_MODE = 0,
  parameter logic [DATA_W-1:0] CLR_VAL    = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_en0,
  input  logic [DATA_W/8-1:0]   i_wen0,
  input  logic [ADDR_W-1:0]     i_adr0,
  input  logic [DATA_W-1:0]     i_wdata0,
  output logic [DATA_W-1:0]     o_rdata0,
  output logic                  o_rvalid0,
  input  logic                  i_en1,
  input  logic [DATA_W/8-1:0]   i_wen1,
  input  logic [ADDR_W-1:0]     i_adr1,
  input  logic [DATA_W-1:0]     i_wdata1,
  output logic [DATA_W-1:0]     o_rdata1,
  output logic                  o_rvalid1,
  input  logic                  i_clear,
  output logic                  o_ready,
  output logic                  o_collision
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic {S_CLEAR, S_READY} state_e;

  state_e                       state_q, state_d;
  logic [ADDR_W-1:0]            cnt_q, cnt_d;
  logic [DATA_W-1:0]            mem [DEPTH];

  logic                         ready;
  logic [1:0]                   acc;
  logic [1:0][NB-1:0]           wen;
  logic [1:0][ADDR_W-1:0]       adr;
  logic [1:0][DATA_W-1:0]       wdata;
  logic [1:0][DATA_W-1:0]       rd_word;

  logic [1:0][DATA_W-1:0]       rdata1_q, rdata1_d;
  logic [1:0]                   rvalid1_q, rvalid1_d;
  logic [1:0][DATA_W-1:0]       rdata2_q, rdata2_d;
  logic [1:0]                   rvalid2_q, rvalid2_d;
  logic                         coll_q, coll_d;

  // Gate port requests with the clear engine state; writes only happen on accepted accesses
  always_comb begin
    ready    = (state_q == S_READY);
    acc      = {i_en1, i_en0} & {2{ready}};
    wen[0]   = i_wen0 & {NB{acc[0]}};
    wen[1]   = i_wen1 & {NB{acc[1]}};
    adr[0]   = i_adr0;
    adr[1]   = i_adr1;
    wdata[0] = i_wdata0;
    wdata[1] = i_wdata1;
  end

  // Per-port read word: pre-cycle contents, optionally merged with this port's own write only
  always_comb begin
    rd_word = '0;
    for (int p = 0; p < 2; p++) begin
      rd_word[p] = mem[adr[p]];
      if (WRITE_MODE == 0) begin
        for (int b = 0; b < int'(NB); b++) begin
          if (wen[p][b]) rd_word[p][8*b +: 8] = wdata[p][8*b +: 8];
        end
      end
    end
  end

  // Read pipeline and collision detect; stage 2 only feeds the outputs when OUT_REG is set
  always_comb begin
    rvalid1_d = acc;
    rvalid2_d = rvalid1_q;
    for (int p = 0; p < 2; p++) begin
      rdata1_d[p] = acc[p] ? rd_word[p] : rdata1_q[p];
      rdata2_d[p] = rvalid1_q[p] ? rdata1_q[p] : rdata2_q[p];
    end
    coll_d = acc[0] & acc[1] & (adr[0] == adr[1]) & ((|wen[0]) | (|wen[1]));
  end

  // Clear engine: sweep every entry once, then accept accesses until a clear request
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == {ADDR_W{1'b1}}) state_d = S_READY;
      end
      S_READY: begin
        if (i_clear) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // Memory array: clear sweep, else port 1 then port 0 so port 0 wins shared byte lanes
  always_ff @(posedge clk) begin
    if (state_q == S_CLEAR) begin
      mem[cnt_q] <= CLR_VAL;
    end else begin
      for (int p = 1; p >= 0; p--) begin
        for (int b = 0; b < int'(NB); b++) begin
          if (wen[p][b]) mem[adr[p]][8*b +: 8] <= wdata[p][8*b +: 8];
        end
      end
    end
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_CLEAR;
      cnt_q     <= '0;
      rdata1_q  <= '0;
      rvalid1_q <= '0;
      rdata2_q  <= '0;
      rvalid2_q <= '0;
      coll_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rdata1_q  <= rdata1_d;
      rvalid1_q <= rvalid1_d;
      rdata2_q  <= rdata2_d;
      rvalid2_q <= rvalid2_d;
      coll_q    <= coll_d;
    end
  end

  assign o_rdata0    = (OUT_REG != 0) ? rdata2_q[0]  : rdata1_q[0];
  assign o_rdata1    = (OUT_REG != 0) ? rdata2_q[1]  : rdata1_q[1];
  assign o_rvalid0   = (OUT_REG != 0) ? rvalid2_q[0] : rvalid1_q[0];
  assign o_rvalid1   = (OUT_REG != 0) ? rvalid2_q[1] : rvalid1_q[1];
  assign o_ready     = ready;
  assign o_collision = coll_q;

endmodule

// File: tb/tb_xil_mem_dp_be.sv
// tb/tb_xil_mem_dp_be.sv - scoreboard bench for xil_mem_dp_be, two configurations in lockstep
module tb_xil_mem_dp_be;

  localparam logic [31:0] CLR = 32'hA5A5A5A5;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en0 = 1'b0, en1 = 1'b0, clear = 1'b0;
  logic [3:0]  wen0 = '0, wen1 = '0, adr0 = '0, adr1 = '0;
  logic [31:0] wd0 = '0, wd1 = '0;

  logic [31:0] ua_rdata0, ua_rdata1, ub_rdata0, ub_rdata1;
  logic        ua_rvalid0, ua_rvalid1, ub_rvalid0, ub_rvalid1;
  logic        ua_ready, ub_ready, ua_coll, ub_coll;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic [31:0] model [16];
  exp_t        sbq [4][$];

  always #5 clk = ~clk;

  xil_mem_dp_be #(.DATA_W(32), .ADDR_W(4), .OUT_REG(0), .WRITE_MODE(0), .CLR_VAL(CLR)) ua (
    .clk(clk), .rst_n(rst_n),
    .i_en0(en0), .i_wen0(wen0), .i_adr0(adr0), .i_wdata0(wd0), .o_rdata0(ua_rdata0), .o_rvalid0(ua_rvalid0),
    .i_en1(en1), .i_wen1(wen1), .i_adr1(adr1), .i_wdata1(wd1), .o_rdata1(ua_rdata1), .o_rvalid1(ua_rvalid1),
    .i_clear(clear), .o_ready(ua_ready), .o_collision(ua_coll)
  );

  xil_mem_dp_be #(.DATA_W(32), .ADDR_W(4), .OUT_REG(1), .WRITE_MODE(1), .CLR_VAL(CLR)) ub (
    .clk(clk), .rst_n(rst_n),
    .i_en0(en0), .i_wen0(wen0), .i_adr0(adr0), .i_wdata0(wd0), .o_rdata0(ub_rdata0), .o_rvalid0(ub_rvalid0),
    .i_en1(en1), .i_wen1(wen1), .i_adr1(adr1), .i_wdata1(wd1), .o_rdata1(ub_rdata1), .o_rvalid1(ub_rvalid1),
    .i_clear(clear), .o_ready(ub_ready), .o_collision(ub_coll)
  );

  task automatic model_clear();
    for (int i = 0; i < 16; i++) model[i] = CLR;
  endtask

  task automatic idle();
    en0 = 1'b0; en1 = 1'b0; wen0 = '0; wen1 = '0; clear = 1'b0;
  endtask

  // Drive one access cycle on both ports and record what each configuration must return
  task automatic issue(input logic e0, input logic [3:0] w0, input logic [3:0] a0, input logic [31:0] d0,
                       input logic e1, input logic [3:0] w1, input logic [3:0] a1, input logic [31:0] d1);
    logic [31:0] pre0, pre1, m0, m1;
    en0 = e0; wen0 = w0; adr0 = a0; wd0 = d0;
    en1 = e1; wen1 = w1; adr1 = a1; wd1 = d1;
    pre0 = model[a0]; pre1 = model[a1];
    m0 = pre0; m1 = pre1;
    for (int b = 0; b < 4; b++) begin
      if (w0[b]) m0[8*b +: 8] = d0[8*b +: 8];
      if (w1[b]) m1[8*b +: 8] = d1[8*b +: 8];
    end
    if (e0) begin
      sbq[0].push_back('{m0, cyc + 1});
      sbq[2].push_back('{pre0, cyc + 2});
    end
    if (e1) begin
      sbq[1].push_back('{m1, cyc + 1});
      sbq[3].push_back('{pre1, cyc + 2});
    end
    for (int b = 0; b < 4; b++) if (e1 && w1[b]) model[a1][8*b +: 8] = d1[8*b +: 8];
    for (int b = 0; b < 4; b++) if (e0 && w0[b]) model[a0][8*b +: 8] = d0[8*b +: 8];
  endtask

  // Advance one clock; pop the scoreboard for every read strobe seen at the falling edge
  task automatic step();
    logic [3:0]  v;
    logic [31:0] d [4];
    exp_t        e;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    v = {ub_rvalid1, ub_rvalid0, ua_rvalid1, ua_rvalid0};
    d[0] = ua_rdata0; d[1] = ua_rdata1; d[2] = ub_rdata0; d[3] = ub_rdata1;
    for (int i = 0; i < 4; i++) begin
      while (sbq[i].size() > 0 && sbq[i][0].due < cyc) begin
        e = sbq[i].pop_front();
        n_cmp++; n_err++;
        $display("FAIL missing_rvalid[%0d] cyc=%0d: no strobe, required data %h at cyc %0d", i, cyc, e.data, e.due);
      end
      if (v[i] === 1'b1) begin
        n_cmp++;
        if (sbq[i].size() == 0) begin
          n_err++;
          $display("FAIL unexpected_rvalid[%0d] cyc=%0d: strobe with data %h, required no strobe", i, cyc, d[i]);
        end else begin
          e = sbq[i].pop_front();
          if (d[i] !== e.data || cyc != e.due) begin
            n_err++;
            $display("FAIL rdata[%0d]: got %h at cyc %0d, required %h at cyc %0d", i, d[i], cyc, e.data, e.due);
          end
        end
      end
    end
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!(ua_ready === 1'b1) && n < 100) begin
      step();
      n++;
    end
  endtask

  task automatic read_all();
    for (int i = 0; i < 16; i++) begin
      issue(1'b1, 4'h0, 4'(i), 32'h0, 1'b1, 4'h0, 4'(15 - i), 32'h0);
      step();
    end
    idle();
    repeat (3) step();
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0;
    en0 = 1'b1; en1 = 1'b1; wen0 = 4'hF; adr0 = 4'h0; wd0 = 32'h12345678; adr1 = 4'h9;
    repeat (3) step();
    n_cmp++;
    if ({ua_rdata0, ua_rdata1, ub_rdata0, ub_rdata1} !== 128'h0 ||
        {ua_rvalid0, ua_rvalid1, ub_rvalid0, ub_rvalid1, ua_ready, ub_ready, ua_coll, ub_coll} !== 8'h0) begin
      n_err++;
      $display("FAIL reset_values: rdata=%h %h %h %h flags=%b, required all zero", ua_rdata0, ua_rdata1,
               ub_rdata0, ub_rdata1, {ua_rvalid0, ua_rvalid1, ub_rvalid0, ub_rvalid1, ua_ready, ub_ready, ua_coll, ub_coll});
    end
    rst_n = 1'b1;
    model_clear();
    wait_ready(n);
    idle();
    n_cmp++;
    if (n != 16 || ub_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready_latency: got %0d cycles (ub_ready=%b), required 16", n, ub_ready);
    end
    read_all();
  endtask

  task automatic test_byte_enables();
    issue(1'b1, 4'hF, 4'd3, 32'h11223344, 1'b0, 4'h0, 4'd0, 32'h0);
    step();
    issue(1'b1, 4'b0101, 4'd3, 32'hAABBCCDD, 1'b0, 4'h0, 4'd0, 32'h0);
    step();
    issue(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'h0, 4'd3, 32'h0);
    step();
    n_cmp++;
    if (ua_rdata1 !== 32'h11BB33DD) begin
      n_err++;
      $display("FAIL byte_enable_merge: got %h, required 11bb33dd", ua_rdata1);
    end
    idle();
    repeat (3) step();
  endtask

  task automatic test_write_mode();
    issue(1'b1, 4'hF, 4'd5, 32'h0, 1'b0, 4'h0, 4'd0, 32'h0);
    step();
    issue(1'b1, 4'hF, 4'd5, 32'hDEADBEEF, 1'b0, 4'h0, 4'd0, 32'h0);
    step();
    n_cmp++;
    if (ua_rdata0 !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL write_first_rdw: got %h, required deadbeef", ua_rdata0);
    end
    idle();
    step();
    n_cmp++;
    if (ub_rdata0 !== 32'h0) begin
      n_err++;
      $display("FAIL read_first_rdw: got %h, required 00000000", ub_rdata0);
    end
    issue(1'b1, 4'h0, 4'd5, 32'h0, 1'b0, 4'h0, 4'd0, 32'h0);
    step();
    idle();
    step();
    n_cmp++;
    if (ua_rdata0 !== 32'hDEADBEEF || ub_rdata0 !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL write_mode_reread: got %h / %h, required deadbeef / deadbeef", ua_rdata0, ub_rdata0);
    end
    repeat (2) step();
  endtask

  task automatic test_collision();
    issue(1'b1, 4'hF, 4'd7, 32'h1, 1'b1, 4'hF, 4'd7, 32'h2);
    step();
    n_cmp++;
    if (ua_coll !== 1'b1 || ub_coll !== 1'b1) begin
      n_err++;
      $display("FAIL collision_pulse: got %b/%b, required 1/1", ua_coll, ub_coll);
    end
    idle();
    step();
    n_cmp++;
    if (ua_coll !== 1'b0 || ub_coll !== 1'b0) begin
      n_err++;
      $display("FAIL collision_single: got %b/%b, required 0/0", ua_coll, ub_coll);
    end
    issue(1'b1, 4'h0, 4'd7, 32'h0, 1'b0, 4'h0, 4'd0, 32'h0);
    step();
    n_cmp++;
    if (ua_rdata0 !== 32'h1) begin
      n_err++;
      $display("FAIL collision_winner: got %h, required 00000001", ua_rdata0);
    end
    issue(1'b1, 4'h0, 4'd7, 32'h0, 1'b1, 4'h0, 4'd7, 32'h0);
    step();
    n_cmp++;
    if (ua_coll !== 1'b0 || ub_coll !== 1'b0) begin
      n_err++;
      $display("FAIL dual_read_no_collision: got %b/%b, required 0/0", ua_coll, ub_coll);
    end
    issue(1'b1, 4'h0, 4'd9, 32'h0, 1'b1, 4'b0011, 4'd9, 32'h0000BEEF);
    step();
    n_cmp++;
    if (ua_coll !== 1'b1 || ub_coll !== 1'b1) begin
      n_err++;
      $display("FAIL read_write_collision: got %b/%b, required 1/1", ua_coll, ub_coll);
    end
    idle();
    repeat (3) step();
  endtask

  task automatic test_back_to_back();
    logic [5:0] ha, hb;
    for (int k = 0; k < 6; k++) begin
      if (k < 3) issue(1'b1, 4'h0, 4'(k), 32'h0, 1'b1, 4'h0, 4'(k), 32'h0);
      else idle();
      step();
      ha[k] = ua_rvalid0;
      hb[k] = ub_rvalid0;
    end
    n_cmp++;
    if (ha !== 6'b000111 || hb !== 6'b001110) begin
      n_err++;
      $display("FAIL b2b_rvalid_pattern: got %b / %b, required 000111 / 001110", ha, hb);
    end
    n_cmp++;
    if (ua_rdata0 !== CLR || ub_rdata1 !== CLR) begin
      n_err++;
      $display("FAIL rdata_hold: got %h / %h, required %h", ua_rdata0, ub_rdata1, CLR);
    end
  endtask

  task automatic test_clear();
    int n;
    issue(1'b1, 4'hF, 4'd3, 32'hCAFEF00D, 1'b1, 4'hF, 4'd12, 32'h55AA55AA);
    step();
    idle();
    repeat (3) step();
    clear = 1'b1;
    step();
    model_clear();
    n_cmp++;
    if (ua_ready !== 1'b0 || ub_ready !== 1'b0) begin
      n_err++;
      $display("FAIL clear_ready_drop: got %b/%b, required 0/0", ua_ready, ub_ready);
    end
    en0 = 1'b1; en1 = 1'b1; wen0 = 4'hF; adr0 = 4'd4; wd0 = 32'h0BADBAD0;
    repeat (4) step();
    clear = 1'b0;
    wait_ready(n);
    idle();
    n_cmp++;
    if (n + 4 != 16) begin
      n_err++;
      $display("FAIL clear_duration: got %0d cycles, required 16", n + 4);
    end
    read_all();
  endtask

  task automatic test_reset_mid_clear();
    int n;
    clear = 1'b1;
    step();
    clear = 1'b0;
    model_clear();
    repeat (5) step();
    rst_n = 1'b0;
    step();
    n_cmp++;
    if (ua_ready !== 1'b0 || ua_rdata0 !== 32'h0 || ub_rdata1 !== 32'h0) begin
      n_err++;
      $display("FAIL mid_clear_reset_values: ready=%b rdata=%h/%h, required 0/0/0", ua_ready, ua_rdata0, ub_rdata1);
    end
    rst_n = 1'b1;
    wait_ready(n);
    n_cmp++;
    if (n != 16 || ub_ready !== 1'b1) begin
      n_err++;
      $display("FAIL mid_clear_restart: got %0d cycles (ub_ready=%b), required 16", n, ub_ready);
    end
    read_all();
  endtask

  initial begin
    idle();
    test_reset();
    test_byte_enables();
    test_write_mode();
    test_collision();
    test_back_to_back();
    test_clear();
    test_reset_mid_clear();
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (sbq[i].size() != 0) begin
        n_err++;
        $display("FAIL scoreboard_drain[%0d]: %0d entries left, required 0", i, sbq[i].size());
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/xil_mem_dp_be.md
# xil_mem_dp_be

Parametrised single-clock dual-port RAM with per-byte write enables, selectable write mode, optional output register, hardware clear engine and cross-port collision reporting. It replaces the fixed-size 8-bit dual-port memories in mailbox, buffer and directory storage. Users get one RTL model for both simulation and synthesis.

## Interface
- DATA_W, 32: word width in bits, multiple of 8, range 8..256; NB = DATA_W/8 byte lanes.
- ADDR_W, 11: address width; depth = 2^ADDR_W.
- OUT_REG, 0: 0 = read latency 1; 1 = extra output register, read latency 2.
- WRITE_MODE, 0: 0 = write-first, 1 = read-first. Applies to same-port read-during-write only.
- CLR_VAL, 0: DATA_W-bit value written to every entry by the clear engine.

Ports:
- clk  in  1  single clock for both ports.
- rst_n  in  1  asynchronous, active-low reset.
- i_en0  in  1  port 0 access enable.
- i_wen0  in  NB  port 0 byte write enables. Effective only with i_en0.
- i_adr0  in  ADDR_W  port 0 address.
- i_wdata0  in  DATA_W  port 0 write data.
- o_rdata0  out  DATA_W  port 0 read data.
- o_rvalid0  out  1  port 0 read-data-valid strobe.
- i_en1, i_wen1, i_adr1, i_wdata1, o_rdata1, o_rvalid1: port 1, identical to port 0.
- i_clear  in  1  request full-memory clear. Sampled in READY only.
- o_ready  out  1  clear engine idle; port accesses accepted.
- o_collision  out  1  one-cycle pulse reporting a same-address conflict.

## Operation
- Clear FSM states: CLEAR, READY.
  - Reset enters CLEAR with clear counter = 0.
  - In CLEAR, each cycle writes CLR_VAL, all bytes, to entry counter; counter +1.
  - After entry 2^ADDR_W-1 is written, go to READY. CLEAR lasts exactly 2^ADDR_W cycles.
  - In READY, i_clear=1 returns to CLEAR with counter = 0.
  - In CLEAR, i_clear is ignored and the counter does not restart.
- In CLEAR, port enables are ignored: no writes, no o_rvalid, o_rdata held. Requesters must wait for o_ready.
- Access in READY with i_en=1 is a read of i_adr. The read is reported even when bytes are written.
  - Bytes with i_wen[b]=1 write i_wdata[8b+7:8b].
  - Other bytes keep their contents.
- Same-port read-during-write:
  - WRITE_MODE=0: o_rdata shows the merged new word.
  - WRITE_MODE=1: o_rdata shows the pre-write word.
- Cross-port access, both enabled, same address, same cycle:
  - Each port's read data ignores the other port's write in that cycle and returns the pre-cycle word, plus its own write if write-first.
  - If both write the same byte lane, port 0 wins.
  - Collision condition: at least one port writes at least one byte. It produces o_collision=1 in the following cycle. Two reads do not collide.
- o_rdata holds its last value while no read completes.
- Memory array contents are not reset; only the clear engine initialises them.

## Timing
- Reset values: o_rdata0/1 = 0, o_rvalid0/1 = 0, o_ready = 0, o_collision = 0. FSM = CLEAR, counter = 0.
- Reset asserted mid-CLEAR or mid-access aborts the operation. The clear restarts from entry 0 after rst_n deasserts.
- First rising edge after rst_n deasserts writes entry 0. o_ready rises the cycle after entry 2^ADDR_W-1 is written, i.e. 2^ADDR_W cycles after reset release.
- i_clear sampled at edge T: o_ready=0 from T+1. Entry 0 is written at edge T+1. o_ready returns at T+1+2^ADDR_W.
- Read latency:
  - OUT_REG=0: request at edge T, o_rdata/o_rvalid valid after T, until T+1.
  - OUT_REG=1: one cycle later.
  - o_rvalid is a one-cycle pulse per accepted request.
- Back-to-back accesses are allowed every cycle on both ports, with full throughput.
- o_collision is registered and aligns with the cycle in which OUT_REG=0 read data appears, independent of OUT_REG.

## Test plan
- Reset release, ADDR_W=4, CLR_VAL=32'hA5A5A5A5:
  - o_ready rises exactly 16 cycles after rst_n high.
  - Reading all 16 entries returns A5A5A5A5.
  - Port enables during CLEAR produce no o_rvalid.
- Byte enables, DATA_W=32:
  - Write 32'h11223344 to address 3 with wen=4'b1111.
  - Then write 32'hAABBCCDD with wen=4'b0101.
  - Read returns 32'h11BB33DD.
- Write mode: same-port write of 32'hDEADBEEF over 0 at address 5.
  - WRITE_MODE=0: rdata = DEADBEEF.
  - WRITE_MODE=1: rdata = 0.
  - Next read returns DEADBEEF in both modes.
- Collision at address 7: port 0 writes 32'h1, port 1 writes 32'h2, all bytes, same cycle.
  - o_collision pulses once.
  - A later read returns 32'h1.
  - Same-address dual reads produce no pulse.
- OUT_REG=1 with back-to-back reads of addresses 0,1,2 on both ports:
  - Data appears at latency 2 in order.
  - o_rvalid is high for 3 consecutive cycles.
- Mid-clear events:
  - i_clear in READY after writes: all entries return CLR_VAL.
  - rst_n pulsed during CLEAR: the clear restarts from entry 0, and o_ready timing matches the fresh-reset case.
